l2_merge_ctrl: RTL and testbench
================================

# l2_merge_ctrl

Parametrised N-master native-bus merge with round-robin arbitration and safe L2 invalidate sequencing. Sits between the L1 cache back-ends (instruction, data, accelerator) and the L2 cache front-end in the external-memory subsystem. It replaces the fixed-priority merge and the ad-hoc invalidate latch: any master may request an L2 invalidate, and the block issues it only when no L2 transaction is in flight.

## Interface
Parameters:
- N_MASTERS, 2: number of master ports, 1..8.
- ADDR_W, 30: word-address width.
- DATA_W, 32: data width, multiple of 8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- m_valid  input  N_MASTERS  per-master request valid.
- m_addr  input  N_MASTERS*ADDR_W  per-master word address; master i in slice i.
- m_wdata  input  N_MASTERS*DATA_W  per-master write data.
- m_wstrb  input  N_MASTERS*DATA_W/8  per-master byte strobes; all zero means read.
- m_rdata  output  DATA_W  read data, s_rdata broadcast to all masters.
- m_ready  output  N_MASTERS  per-master completion, one-hot or zero.
- inv_req  input  N_MASTERS  per-master L2 invalidate request pulse.
- s_valid  output  1  request to L2.
- s_addr  output  ADDR_W  address to L2.
- s_wdata  output  DATA_W  write data to L2.
- s_wstrb  output  DATA_W/8  strobes to L2.
- s_rdata  input  DATA_W  L2 read data.
- s_ready  input  1  L2 completion.
- s_inv  output  1  one-cycle invalidate pulse to L2.
- inv_busy  output  1  high while an invalidate is pending or being issued.

## Operation
- Registers: state {IDLE, BUSY}, grant index, last-served index, inv_pending.
- Reset values: state IDLE, grant 0, last-served N_MASTERS-1 (so master 0 wins first), inv_pending 0. Outputs at reset: s_valid 0, s_inv 0, m_ready 0, inv_busy 0. s_addr, s_wdata and s_wstrb are 0.
- inv_pending is set on any inv_req bit. It is cleared in the cycle s_inv is asserted, unless an inv_req bit is also high in that cycle, in which case it stays set.
- IDLE, inv_pending=1: assert s_inv for exactly one cycle and stay in IDLE. Invalidate has priority over new grants.
- IDLE, inv_pending=0, any m_valid: grant the first requesting master, searching last-served+1 cyclically (modulo N_MASTERS). Register the grant and go to BUSY.
- IDLE with no request: stay in IDLE.
- BUSY: s_valid = m_valid[grant]. s_addr, s_wdata and s_wstrb are muxed from the granted slice. m_ready[grant] = s_ready; all other m_ready bits are 0.
- BUSY with s_ready=1: set last-served to grant and return to IDLE.
- BUSY with m_valid[grant]=0 (protocol violation): return to IDLE with no completion.
- inv_req arriving during BUSY latches. The in-flight transaction completes first; s_inv is never asserted while state is BUSY.
- inv_busy = inv_pending | s_inv.
- With N_MASTERS=1 the arbiter degenerates to a fixed grant of 0.

## Timing
- Arbitration costs one cycle: m_valid seen in IDLE at cycle t gives s_valid at t+1.
- m_ready is combinational from s_ready in the same cycle.
- Back-to-back: after completion at t, the next grant happens in IDLE at t+1, so s_valid is next high at t+2.
- Invalidate latency: inv_req at t while IDLE and no other pending work gives s_inv at t+1. If BUSY, s_inv comes in the cycle after the completion cycle.
- Masters hold valid, addr, wdata and wstrb stable until their m_ready.
- Reset asserted mid-transaction: s_valid, s_inv and m_ready drop immediately (asynchronously), and any pending invalidate is discarded.

## Test plan
- Single read: master 0 reads addr 0x10 and L2 returns 0xDEADBEEF after 3 cycles. Expect s_valid one cycle after m_valid, m_ready=01 in the s_ready cycle, m_rdata=0xDEADBEEF.
- Round-robin: N_MASTERS=3, all masters continuously valid. Expect grant order 0,1,2,0,1,2, and each m_ready is one-hot on the matching master.
- Invalidate during BUSY: master 1 writes with wstrb=0xF, and inv_req[0] pulses in the write's second cycle. Expect s_inv exactly one cycle after the write's s_ready, never overlapping s_valid, and inv_busy high from the inv_req cycle through the s_inv cycle.
- Invalidate priority: inv_req and m_valid rise together in IDLE. Expect s_inv at t+1, grant at t+2, s_valid at t+3.
- Re-request during issue: inv_req high again in the s_inv cycle. Expect a second s_inv pulse in the next IDLE cycle.
- Reset mid-transaction: assert rst low during BUSY. Expect s_valid=0 and m_ready=0 immediately; after release, master 0 has priority.

Source files
------------

// File: rtl/l2_merge_ctrl.sv
// rtl/l2_merge_ctrl.sv - N-master round-robin merge onto the L2 front-end with invalidate sequencing
module l2_merge_ctrl #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    input  logic [N_MASTERS-1:0]          inv_req,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic                          s_inv,
    output logic                          inv_busy
);

    localparam int SW = DATA_W / 8;
    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic            inv_pending_q, inv_pending_d;

    logic [GW-1:0]   rr_pick;
    logic            rr_found;
    logic            busy;
    logic            inv_any;

    assign busy    = (state_q == BUSY);
    assign inv_any = |inv_req;

    // First requester after the last-served master, wrapping modulo N_MASTERS.
    always_comb begin
        int            idx_int;
        logic [GW-1:0] idx;
        rr_pick  = '0;
        rr_found = 1'b0;
        idx_int  = 0;
        idx      = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx_int = (int'(last_q) + i) % N_MASTERS;
            idx     = GW'(idx_int);
            if (!rr_found && m_valid[idx]) begin
                rr_found = 1'b1;
                rr_pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // A same-cycle inv_req already counts as pending, so it beats a new grant.
                if (!inv_pending_q && !inv_any && rr_found) begin
                    grant_d = rr_pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end else if (!m_valid[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_inv         = (state_q == IDLE) && inv_pending_q;
    assign inv_pending_d = inv_any || (inv_pending_q && !s_inv);
    assign inv_busy      = inv_pending_q || inv_any || s_inv;

    always_comb begin
        s_valid = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        m_ready = '0;
        if (busy) begin
            s_valid = m_valid[grant_q];
            s_addr  = m_addr[grant_q*ADDR_W +: ADDR_W];
            s_wdata = m_wdata[grant_q*DATA_W +: DATA_W];
            s_wstrb = m_wstrb[grant_q*SW +: SW];
            for (int i = 0; i < N_MASTERS; i++) begin
                m_ready[i] = s_ready && (grant_q == GW'(i));
            end
        end
    end

    assign m_rdata = s_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_q        <= GW'(N_MASTERS - 1);
            inv_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            inv_pending_q <= inv_pending_d;
        end
    end

endmodule

// File: tb/tb_l2_merge_ctrl.sv
// tb/tb_l2_merge_ctrl.sv - randomized self-checking bench for l2_merge_ctrl
module tb_l2_merge_ctrl;

    localparam int N  = 3;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_valid;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic [DW-1:0]     m_rdata;
    logic [N-1:0]      m_ready;
    logic [N-1:0]      inv_req;
    logic              s_valid;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic [DW-1:0]     s_rdata;
    logic              s_ready;
    logic              s_inv;
    logic              inv_busy;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] addr_a  [N];
    logic [DW-1:0] wdata_a [N];
    logic [SW-1:0] wstrb_a [N];
    int            exp_last;

    l2_merge_ctrl #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready), .inv_req(inv_req),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready), .s_inv(s_inv), .inv_busy(inv_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (exp_last + k) % N;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic randomize_masters();
        for (int i = 0; i < N; i++) begin
            addr_a[i]      = AW'($urandom);
            addr_a[i][1:0] = 2'(i);
            wdata_a[i]     = $urandom;
            wstrb_a[i]     = SW'($urandom_range(0, 15));
        end
    endtask

    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]  = addr_a[i];
            m_wdata[i*DW +: DW] = wdata_a[i];
            m_wstrb[i*SW +: SW] = wstrb_a[i];
        end
    endtask

    // Starts in an idle cycle just after a rising edge; ends likewise, one cycle after completion.
    task automatic do_txn(input logic [N-1:0] mask, input int delay, input logic [DW-1:0] rd, input string tag);
        int g;
        logic [N-1:0] exp_rdy;
        drive_masters();
        m_valid = mask;
        @(negedge clk);
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s arb_cycle s_valid got %b exp 0", tag, s_valid);
        end
        g = model_pick(mask);
        step();
        for (int d = 0; d <= delay; d++) begin
            s_ready = (d == delay);
            s_rdata = (d == delay) ? rd : DW'($urandom);
            exp_rdy = (d == delay) ? (N'(1) << g) : '0;
            @(negedge clk);
            checks++;
            if (s_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s s_valid got %b exp 1", tag, s_valid);
            end
            checks++;
            if (s_addr !== addr_a[g]) begin
                errors++;
                $display("FAIL %s s_addr got %h exp %h (master %0d)", tag, s_addr, addr_a[g], g);
            end
            checks++;
            if ({s_wdata, s_wstrb} !== {wdata_a[g], wstrb_a[g]}) begin
                errors++;
                $display("FAIL %s wdata/wstrb got %h/%h exp %h/%h", tag, s_wdata, s_wstrb, wdata_a[g], wstrb_a[g]);
            end
            checks++;
            if (m_ready !== exp_rdy) begin
                errors++;
                $display("FAIL %s m_ready got %b exp %b", tag, m_ready, exp_rdy);
            end
            if (d == delay) begin
                checks++;
                if (m_rdata !== rd) begin
                    errors++;
                    $display("FAIL %s m_rdata got %h exp %h", tag, m_rdata, rd);
                end
            end
            if (d < delay) step();
        end
        exp_last = g;
        step();
        s_ready = 1'b0;
        m_valid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_valid, s_inv, m_ready, inv_busy} !== '0) begin
            errors++;
            $display("FAIL reset ctrl got v=%b inv=%b rdy=%b busy=%b exp all 0", s_valid, s_inv, m_ready, inv_busy);
        end
        checks++;
        if ({s_addr, s_wdata, s_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset bus got %h/%h/%h exp 0", s_addr, s_wdata, s_wstrb);
        end
        rst = 1'b1;
        exp_last = N - 1;
        step();
    endtask

    task automatic test_single_read();
        randomize_masters();
        addr_a[0]  = AW'('h10);
        wstrb_a[0] = '0;
        do_txn(3'b001, 2, 32'hDEADBEEF, "single_read");
    endtask

    task automatic test_round_robin();
        randomize_masters();
        for (int n = 0; n < 6; n++) begin
            do_txn(3'b111, $urandom_range(0, 2), $urandom, "round_robin");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 10; n++) begin
            randomize_masters();
            do_txn(N'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom, "back_to_back");
        end
    endtask

    task automatic test_inv_during_busy();
        int extra;
        randomize_masters();
        wstrb_a[1] = 4'hF;
        drive_masters();
        m_valid = 3'b010;
        step();
        step();
        inv_req = 3'b001;
        @(negedge clk);
        checks++;
        if ({inv_busy, s_inv, s_valid} !== 3'b101) begin
            errors++;
            $display("FAIL inv_busy_req_cycle busy/inv/valid got %b%b%b exp 101", inv_busy, s_inv, s_valid);
        end
        extra = $urandom_range(1, 3);
        for (int k = 1; k <= extra; k++) begin
            step();
            inv_req = '0;
            s_ready = (k == extra);
            @(negedge clk);
            checks++;
            if ({inv_busy, s_inv, s_valid} !== 3'b101) begin
                errors++;
                $display("FAIL inv_busy_wait busy/inv/valid got %b%b%b exp 101", inv_busy, s_inv, s_valid);
            end
        end
        checks++;
        if (m_ready !== 3'b010) begin
            errors++;
            $display("FAIL inv_busy_done m_ready got %b exp 010", m_ready);
        end
        exp_last = 1;
        step();
        s_ready = 1'b0;
        m_valid = '0;
        @(negedge clk);
        checks++;
        if ({inv_busy, s_inv, s_valid} !== 3'b110) begin
            errors++;
            $display("FAIL inv_busy_issue busy/inv/valid got %b%b%b exp 110", inv_busy, s_inv, s_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if ({inv_busy, s_inv} !== 2'b00) begin
            errors++;
            $display("FAIL inv_busy_after busy/inv got %b%b exp 00", inv_busy, s_inv);
        end
        step();
    endtask

    task automatic test_inv_priority();
        logic [N-1:0] mask;
        int g;
        randomize_masters();
        drive_masters();
        mask    = N'($urandom_range(1, 7));
        m_valid = mask;
        inv_req = N'(1) << $urandom_range(0, N - 1);
        @(negedge clk);
        checks++;
        if ({s_inv, s_valid, inv_busy} !== 3'b001) begin
            errors++;
            $display("FAIL inv_prio_t inv/valid/busy got %b%b%b exp 001", s_inv, s_valid, inv_busy);
        end
        step();
        inv_req = '0;
        @(negedge clk);
        checks++;
        if ({s_inv, s_valid} !== 2'b10) begin
            errors++;
            $display("FAIL inv_prio_t1 inv/valid got %b%b exp 10", s_inv, s_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if ({s_inv, s_valid} !== 2'b00) begin
            errors++;
            $display("FAIL inv_prio_t2 inv/valid got %b%b exp 00", s_inv, s_valid);
        end
        g = model_pick(mask);
        step();
        s_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_valid, s_addr, m_ready} !== {1'b1, addr_a[g], N'(1) << g}) begin
            errors++;
            $display("FAIL inv_prio_t3 valid/addr/rdy got %b/%h/%b exp 1/%h/%b", s_valid, s_addr, m_ready, addr_a[g], N'(1) << g);
        end
        exp_last = g;
        step();
        s_ready = 1'b0;
        m_valid = '0;
    endtask

    task automatic test_inv_rerequest();
        inv_req = N'(1) << $urandom_range(0, N - 1);
        @(negedge clk);
        checks++;
        if (s_inv !== 1'b0) begin
            errors++;
            $display("FAIL rereq_t s_inv got %b exp 0", s_inv);
        end
        step();
        inv_req = N'(1) << $urandom_range(0, N - 1);
        @(negedge clk);
        checks++;
        if (s_inv !== 1'b1) begin
            errors++;
            $display("FAIL rereq_first s_inv got %b exp 1", s_inv);
        end
        step();
        inv_req = '0;
        @(negedge clk);
        checks++;
        if ({s_inv, inv_busy} !== 2'b11) begin
            errors++;
            $display("FAIL rereq_second inv/busy got %b%b exp 11", s_inv, inv_busy);
        end
        step();
        @(negedge clk);
        checks++;
        if ({s_inv, inv_busy} !== 2'b00) begin
            errors++;
            $display("FAIL rereq_done inv/busy got %b%b exp 00", s_inv, inv_busy);
        end
        step();
    endtask

    task automatic test_reset_mid();
        randomize_masters();
        drive_masters();
        m_valid = N'($urandom_range(1, 7));
        step();
        inv_req = 3'b100;
        @(negedge clk);
        checks++;
        if (s_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy s_valid got %b exp 1", s_valid);
        end
        #1;
        inv_req = '0;
        s_ready = 1'b1;
        rst     = 1'b0;
        #1;
        checks++;
        if ({s_valid, s_inv, m_ready} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async valid/inv/rdy got %b/%b/%b exp 0/0/000", s_valid, s_inv, m_ready);
        end
        @(posedge clk);
        #1;
        s_ready = 1'b0;
        m_valid = '0;
        rst     = 1'b1;
        exp_last = N - 1;
        @(negedge clk);
        checks++;
        if ({s_inv, inv_busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_inv_discard inv/busy got %b%b exp 00", s_inv, inv_busy);
        end
        step();
        randomize_masters();
        do_txn(3'b111, 1, $urandom, "reset_mid_prio");
    endtask

    initial begin
        rst     = 1'b0;
        m_valid = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        inv_req = '0;
        s_rdata = '0;
        s_ready = 1'b0;
        exp_last = N - 1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_inv_during_busy();
        test_inv_priority();
        test_inv_rerequest();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
